cpu_accel_loopback: RTL and testbench
=====================================

# cpu_accel_loopback

Parametrised multi-channel accelerator endpoint for the `cpu` accelerator port, used in CPU benches and bring-up builds instead of tying `accel_can_read`/`accel_can_write` high and `accel_read_data` to a constant. Each accelerator ID selects one of `CHANNELS` independent FIFOs. A CPU write to an ID pushes a word into that channel, and a CPU read pops it back in FIFO order. Back-pressure is driven from the real fill state, so the bench can exercise the CPU's full/empty stall paths.

## Interface
- `DATA_WIDTH`, 16: accelerator data word width.
- `ID_WIDTH`, 4: width of `accel_id`.
- `CHANNELS`, 4: number of FIFO channels, 1..2^`ID_WIDTH`.
- `DEPTH`, 8: entries per channel; power of two, ≥2.
- `clk` in 1: clock; all state changes on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `accel_id` in `ID_WIDTH`: channel select from the CPU.
- `accel_can_read` out 1: the selected channel is valid and non-empty.
- `accel_can_write` out 1: the selected channel is valid and not full.
- `accel_read_enable` in 1: pop request.
- `accel_read_data` out `DATA_WIDTH`: head word of the selected channel.
- `accel_write_enable` in 1: push request.
- `accel_write_data` in `DATA_WIDTH`: word to push.
- `fill_level` out `CHANNELS*($clog2(DEPTH)+1)`: per-channel occupancy. Channel c occupies bits [c*W +: W], where W = $clog2(DEPTH)+1.

## Operation
- Per-channel state: read pointer and write pointer of width $clog2(DEPTH), wrapping modulo `DEPTH`, and a count of width W holding 0..`DEPTH`.
- Valid ID: `accel_id` < `CHANNELS`.
- Invalid ID:
  - `accel_can_read`=0, `accel_can_write`=0, `accel_read_data`=0.
  - Both enables are ignored.
- Push: occurs when `accel_write_enable` && `accel_can_write`. The word is stored at the write pointer, which then increments, and the count increments.
- Pop: occurs when `accel_read_enable` && `accel_can_read`. The read pointer increments and the count decrements.
- Enable without permission: no state change, and the data is discarded.
- Simultaneous push and pop in one cycle (always the same channel, since there is one ID):
  - Both are evaluated against the pre-edge count.
  - Full channel: the pop succeeds and the write is refused, because `accel_can_write` is 0.
  - Empty channel: the push succeeds and the read is refused.
  - Otherwise both succeed and the count is unchanged.
- Unselected channels hold their state.
- `fill_level` reports the registered count of every channel.

## Timing
- `accel_can_read`, `accel_can_write`, `accel_read_data`:
  - Combinational from `accel_id` and registered channel state.
  - First-word-fall-through: the head word is valid in the same cycle the CPU asserts `accel_read_enable`.
- A pushed word becomes visible on `accel_read_data` in the cycle after the push edge. There is no write-to-read bypass.
- `accel_read_data` is 0 when the selected channel is empty.
- Reset (asynchronous assert, synchronous-safe deassert by the environment):
  - All pointers and counts go to 0, and `fill_level` goes to 0.
  - Storage contents are don't-care, but masked: the empty channel reads 0.
  - `accel_can_read`=0. `accel_can_write`=1 for any valid ID.
- Reset mid-operation discards all queued words immediately, without waiting for a clock edge.

## Configuration
- `CPU_ACCEL_LOOPBACK_ERR_EN` defined adds these ports:
  - `err_clear` in 1.
  - `err_overflow` out `CHANNELS`.
  - `err_underflow` out `CHANNELS`.
- Overflow: `err_overflow[c]` is set on a posedge where `accel_write_enable` is asserted, `accel_id`==c, and the write is refused.
- Underflow: `err_underflow[c]` is set on the same condition with `accel_read_enable` and a refused read.
- Enables on an invalid ID set no bit.
- Error bits are sticky, reset to 0, and clear on `err_clear`. Set takes priority over clear in the same cycle.
- Macro undefined: these ports and their registers do not exist, and refused accesses are silently dropped.

## Test plan
- Reset, `accel_id`=2, no enables:
  - `accel_can_read`=0, `accel_can_write`=1, `accel_read_data`=0, `fill_level`=0.
- Order and isolation:
  - Push 0x1111, 0x2222, 0x3333 to ID 1, then push 0xAAAA to ID 3.
  - Reading ID 1 returns 0x1111, 0x2222, 0x3333 in order.
  - After that, ID 1 has `accel_can_read`=0, and the ID 3 level is still 1.
- Full channel and wrap (`DEPTH`=8):
  - Push 8 words to ID 0: `accel_can_write`=0, and a 9th push is dropped (with ERR_EN, `err_overflow`[0]=1).
  - Pop 3 and push 3: the pointers wrap, and all 8 words read back in push order.
- Simultaneous push and pop:
  - On ID 2 at level 4, read and write in the same cycle: the level stays 4.
  - At level 8, the same access gives level 7 and the written word is lost.
  - At level 0, the same access gives level 1, and `accel_read_data` shows the word the next cycle.
- Invalid ID 5 with `CHANNELS`=4, both enables asserted:
  - Both permissions are 0, `accel_read_data`=0, and no `fill_level` or error bit changes.
- Reset mid-stream:
  - Deassert `rst_n` between clock edges while ID 0 holds 5 words.
  - `fill_level` goes to 0 at once, and after release ID 0 has `accel_can_read`=0.

Source files
------------

// File: rtl/cpu_accel_loopback.sv
// cpu_accel_loopback: multi-channel FIFO endpoint for the CPU accelerator port.
// Each accelerator ID selects one FIFO channel: a write pushes, a read pops.
// Back-pressure follows the real fill state. Read data is first-word-fall-through.
// Optional error reporting is enabled by defining CPU_ACCEL_LOOPBACK_ERR_EN.
module cpu_accel_loopback #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [ID_WIDTH-1:0]                    accel_id,
  output logic                                   accel_can_read,
  output logic                                   accel_can_write,
  input  logic                                   accel_read_enable,
  output logic [DATA_WIDTH-1:0]                  accel_read_data,
  input  logic                                   accel_write_enable,
  input  logic [DATA_WIDTH-1:0]                  accel_write_data,
`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
  input  logic                                   err_clear,
  output logic [CHANNELS-1:0]                    err_overflow,
  output logic [CHANNELS-1:0]                    err_underflow,
`endif
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]  fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
  // One extra bit so CHANNELS == 2**ID_WIDTH still compares correctly.
  localparam logic [ID_WIDTH:0]   CH_LIM   = (ID_WIDTH+1)'(CHANNELS);

  // Storage carries no reset; an empty channel masks its stale contents.
  logic [DATA_WIDTH-1:0] mem [CHANNELS][DEPTH];
  logic [PTR_W-1:0]      rd_ptr [CHANNELS];
  logic [PTR_W-1:0]      wr_ptr [CHANNELS];
  logic [CNT_W-1:0]      cnt    [CHANNELS];

  logic                  id_valid;
  logic [CHANNELS-1:0]   sel_oh;
  logic [CNT_W-1:0]      sel_cnt;
  logic [DATA_WIDTH-1:0] sel_head;
  logic                  push;
  logic                  pop;

  assign id_valid = ({1'b0, accel_id} < CH_LIM);

  // Decode the selected channel and mux out its count and head word.
  always_comb begin
    sel_oh   = '0;
    sel_cnt  = '0;
    sel_head = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (id_valid && (accel_id == ID_WIDTH'(c))) begin
        sel_oh[c] = 1'b1;
        sel_cnt   = cnt[c];
        sel_head  = mem[c][rd_ptr[c]];
      end
    end
  end

  // Permissions and data are combinational from the ID and registered state,
  // so push and pop are judged against the pre-edge count.
  always_comb begin
    accel_can_read  = (|sel_oh) && (sel_cnt != '0);
    accel_can_write = (|sel_oh) && (sel_cnt != FULL_CNT);
    accel_read_data = accel_can_read ? sel_head : '0;
    push            = accel_write_enable && accel_can_write;
    pop             = accel_read_enable && accel_can_read;
  end

  // Pointer and count update for the selected channel; others hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sel_oh[c]) begin
          if (push) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
          if (pop)  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
          if (push && !pop)      cnt[c] <= cnt[c] + CNT_W'(1);
          else if (pop && !push) cnt[c] <= cnt[c] - CNT_W'(1);
        end
      end
    end
  end

  // Accepted words land at the write pointer of the selected channel.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel_oh[c] && push) mem[c][wr_ptr[c]] <= accel_write_data;
    end
  end

  // Expose every channel's registered count.
  always_comb begin
    fill_level = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fill_level[c*CNT_W +: CNT_W] = cnt[c];
    end
  end

`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
  logic [CHANNELS-1:0] ovf_set;
  logic [CHANNELS-1:0] unf_set;

  // A refused enable on a valid ID flags that channel; invalid IDs flag nothing.
  always_comb begin
    ovf_set = sel_oh & {CHANNELS{accel_write_enable && !accel_can_write}};
    unf_set = sel_oh & {CHANNELS{accel_read_enable && !accel_can_read}};
  end

  // Sticky error bits; a new set wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow  <= '0;
      err_underflow <= '0;
    end else begin
      err_overflow  <= (err_clear ? '0 : err_overflow)  | ovf_set;
      err_underflow <= (err_clear ? '0 : err_underflow) | unf_set;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_accel_loopback.sv
// Directed bench for cpu_accel_loopback with default parameters
// (DATA_WIDTH=16, ID_WIDTH=4, CHANNELS=4, DEPTH=8).
module tb_cpu_accel_loopback;

  localparam int LW = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  accel_id;
  logic        accel_can_read;
  logic        accel_can_write;
  logic        accel_read_enable;
  logic [15:0] accel_read_data;
  logic        accel_write_enable;
  logic [15:0] accel_write_data;
  logic [15:0] fill_level;
`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
  logic        err_clear;
  logic [3:0]  err_overflow;
  logic [3:0]  err_underflow;
`endif

  int total = 0;
  int bad   = 0;

  cpu_accel_loopback dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .accel_id           (accel_id),
    .accel_can_read     (accel_can_read),
    .accel_can_write    (accel_can_write),
    .accel_read_enable  (accel_read_enable),
    .accel_read_data    (accel_read_data),
    .accel_write_enable (accel_write_enable),
    .accel_write_data   (accel_write_data),
`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
    .err_clear          (err_clear),
    .err_overflow       (err_overflow),
    .err_underflow      (err_underflow),
`endif
    .fill_level         (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] lvl(input int c);
    return fill_level[c*LW +: LW];
  endfunction

  task automatic push(input logic [3:0] id, input logic [15:0] d);
    accel_id           = id;
    accel_write_data   = d;
    accel_write_enable = 1'b1;
    @(posedge clk); #1;
    accel_write_enable = 1'b0;
  endtask

  task automatic pop_chk(input logic [3:0] id, input logic [15:0] exp, input string tag);
    accel_id          = id;
    accel_read_enable = 1'b1;
    #1;
    check_val({tag, "_rdy"}, {31'd0, accel_can_read}, 32'd1);
    check_val(tag, {16'd0, accel_read_data}, {16'd0, exp});
    @(posedge clk); #1;
    accel_read_enable = 1'b0;
  endtask

  task automatic push_pop(input logic [3:0] id, input logic [15:0] d);
    accel_id           = id;
    accel_write_data   = d;
    accel_write_enable = 1'b1;
    accel_read_enable  = 1'b1;
    @(posedge clk); #1;
    accel_write_enable = 1'b0;
    accel_read_enable  = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    accel_id           = 4'd2;
    accel_read_enable  = 1'b0;
    accel_write_enable = 1'b0;
    accel_write_data   = '0;
`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
    err_clear          = 1'b0;
`endif
    #12 rst_n = 1'b1;
    #1;

    // Reset state
    check_val("rst_can_read",  {31'd0, accel_can_read},  32'd0);
    check_val("rst_can_write", {31'd0, accel_can_write}, 32'd1);
    check_val("rst_rdata",     {16'd0, accel_read_data}, 32'd0);
    check_val("rst_fill",      {16'd0, fill_level},      32'd0);
`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
    check_val("rst_err", {24'd0, err_overflow, err_underflow}, 32'd0);
`endif
    @(posedge clk); #1;

    // Order and isolation
    push(4'd1, 16'h1111);
    push(4'd1, 16'h2222);
    push(4'd1, 16'h3333);
    push(4'd3, 16'hAAAA);
    check_val("iso_lvl1", {28'd0, lvl(1)}, 32'd3);
    check_val("iso_lvl3", {28'd0, lvl(3)}, 32'd1);
    pop_chk(4'd1, 16'h1111, "ord0");
    pop_chk(4'd1, 16'h2222, "ord1");
    pop_chk(4'd1, 16'h3333, "ord2");
    accel_id = 4'd1; #1;
    check_val("ord_empty", {31'd0, accel_can_read}, 32'd0);
    check_val("ord_empty_rdata", {16'd0, accel_read_data}, 32'd0);
    check_val("iso_lvl3_after", {28'd0, lvl(3)}, 32'd1);

    // Full channel and pointer wrap on ID 0
    for (int i = 0; i < 8; i++) push(4'd0, 16'h0100 + 16'(i));
    accel_id = 4'd0; #1;
    check_val("full_can_write", {31'd0, accel_can_write}, 32'd0);
    check_val("full_lvl", {28'd0, lvl(0)}, 32'd8);
    push(4'd0, 16'hDEAD);
    check_val("full_drop_lvl", {28'd0, lvl(0)}, 32'd8);
`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
    check_val("full_ovf", {28'd0, err_overflow}, 32'h1);
`endif
    pop_chk(4'd0, 16'h0100, "wrap_p0");
    pop_chk(4'd0, 16'h0101, "wrap_p1");
    pop_chk(4'd0, 16'h0102, "wrap_p2");
    push(4'd0, 16'h0108);
    push(4'd0, 16'h0109);
    push(4'd0, 16'h010A);
    check_val("wrap_lvl", {28'd0, lvl(0)}, 32'd8);
    for (int i = 0; i < 8; i++) pop_chk(4'd0, 16'h0103 + 16'(i), "wrap_rd");
    check_val("wrap_drained", {28'd0, lvl(0)}, 32'd0);

    // Simultaneous push and pop on ID 2
    for (int i = 0; i < 4; i++) push(4'd2, 16'h2000 + 16'(i));
    push_pop(4'd2, 16'h2F00);
    check_val("pp_mid_lvl", {28'd0, lvl(2)}, 32'd4);
    for (int i = 4; i < 8; i++) push(4'd2, 16'h2000 + 16'(i));
    check_val("pp_full_pre", {28'd0, lvl(2)}, 32'd8);
    push_pop(4'd2, 16'h2F01);
    check_val("pp_full_lvl", {28'd0, lvl(2)}, 32'd7);
`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
    check_val("pp_full_ovf", {28'd0, err_overflow}, 32'h5);
`endif
    pop_chk(4'd2, 16'h2002, "pp_d0");
    pop_chk(4'd2, 16'h2003, "pp_d1");
    pop_chk(4'd2, 16'h2F00, "pp_d2");
    pop_chk(4'd2, 16'h2004, "pp_d3");
    pop_chk(4'd2, 16'h2005, "pp_d4");
    pop_chk(4'd2, 16'h2006, "pp_d5");
    pop_chk(4'd2, 16'h2007, "pp_d6");
    accel_id = 4'd2; #1;
    check_val("pp_lost_word", {31'd0, accel_can_read}, 32'd0);
    push_pop(4'd2, 16'h2F02);
    check_val("pp_empty_lvl", {28'd0, lvl(2)}, 32'd1);
    check_val("pp_empty_rdata", {16'd0, accel_read_data}, 32'h2F02);
`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
    check_val("pp_empty_unf", {28'd0, err_underflow}, 32'h4);
`endif
    pop_chk(4'd2, 16'h2F02, "pp_empty_pop");

    // Invalid ID: only channel 3 holds a word (0xAAAA)
    accel_id           = 4'd5;
    accel_write_data   = 16'hBEEF;
    accel_write_enable = 1'b1;
    accel_read_enable  = 1'b1;
    #1;
    check_val("inv_can_read",  {31'd0, accel_can_read},  32'd0);
    check_val("inv_can_write", {31'd0, accel_can_write}, 32'd0);
    check_val("inv_rdata",     {16'd0, accel_read_data}, 32'd0);
    @(posedge clk); #1;
    accel_write_enable = 1'b0;
    accel_read_enable  = 1'b0;
    check_val("inv_fill", {16'd0, fill_level}, 32'h1000);
`ifdef CPU_ACCEL_LOOPBACK_ERR_EN
    check_val("inv_err", {24'd0, err_overflow, err_underflow}, 32'h54);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check_val("err_cleared", {24'd0, err_overflow, err_underflow}, 32'h0);
`endif

    // Reset mid-stream with 5 words queued on ID 0
    for (int i = 0; i < 5; i++) push(4'd0, 16'h5000 + 16'(i));
    check_val("mid_lvl", {28'd0, lvl(0)}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_fill", {16'd0, fill_level}, 32'd0);
    #3 rst_n = 1'b1;
    accel_id = 4'd0;
    #1;
    check_val("mid_can_read",  {31'd0, accel_can_read},  32'd0);
    check_val("mid_can_write", {31'd0, accel_can_write}, 32'd1);
    check_val("mid_rdata",     {16'd0, accel_read_data}, 32'd0);
    push(4'd0, 16'h6000);
    pop_chk(4'd0, 16'h6000, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
